// File: rtl/imm_gen_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : imm_gen_stage_pkg
// Purpose : Shared definitions for the immediate-generation pipeline stage.
//           The format one-hot bit positions, the FSM state encoding, the
//           buffered entry layout and a one-hot test helper live here.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package imm_gen_stage_pkg;

   // Bit positions inside the one-hot format vector from the decoder
   localparam int FMT_R = 0;
   localparam int FMT_I = 1;
   localparam int FMT_S = 2;
   localparam int FMT_B = 3;
   localparam int FMT_U = 4;
   localparam int FMT_J = 5;
   localparam int FMT_W = 6;

   // Buffer occupancy states
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   // One buffered entry; immediate and target are resolved before storage
   typedef struct packed {
      logic [31:0]       pc;
      logic [31:0]       imm;
      logic [31:0]       target;
      logic [FMT_W-1:0]  fmt;
      logic              illegal;
   } entry_t;

   // True when exactly one bit is set (zero is not one-hot)
   function automatic logic is_onehot6(input logic [FMT_W-1:0] f);
      return (f != '0) && ((f & (f - 6'd1)) == '0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen_stage_imm_decode.sv
`default_nettype none
// ============================================================================
// Module  : imm_decode
// Purpose : Combinational immediate extraction for RISC-V style formats.
// Ports   : inst    in  32  instruction word
//           fmt     in   6  one-hot format [0]R [1]I [2]S [3]B [4]U [5]J
//           imm     out 32  formatted immediate (0 for R or illegal format)
//           illegal out  1  fmt is not exactly one-hot
// Rev     : 1.0  initial release
// ============================================================================
module imm_decode
   import imm_gen_stage_pkg::*;
(
   input  logic [31:0]      inst,
   input  logic [FMT_W-1:0] fmt,
   output logic [31:0]      imm,
   output logic             illegal
);

   // The opcode field never contributes to an immediate
   logic unused_opcode;
   assign unused_opcode = ^inst[6:0];

   always_comb begin
      imm     = '0;
      illegal = !is_onehot6(fmt);
      // Only a clean one-hot format selects an immediate layout
      if (!illegal) begin
         if (fmt[FMT_I]) begin
            imm = {{20{inst[31]}}, inst[31:20]};
         end else if (fmt[FMT_S]) begin
            imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         end else if (fmt[FMT_B]) begin
            imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         end else if (fmt[FMT_U]) begin
            imm = {inst[31:12], 12'b0};
         end else if (fmt[FMT_J]) begin
            imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         end else begin
            imm = '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module  : imm_gen_stage
// Purpose : Valid/ready pipeline stage that decodes the immediate of an
//           instruction, adds it to the pc to form a branch/jump target and
//           buffers the result in an output register plus optional skid
//           register so the stage sustains one transfer per cycle.
// Ports   : i_clk, i_rst            clock, synchronous active-high reset
//           i_valid/o_ready         upstream handshake
//           i_inst, i_pc, i_format  incoming instruction, address, format
//           i_flush                 drop everything held and incoming
//           o_valid/i_ready         downstream handshake
//           o_imm, o_target, o_pc, o_format, o_illegal  output entry
// Params  : SKID  1 = two-entry buffer, 0 = single entry
// Rev     : 1.0  initial release
// ============================================================================
module imm_gen_stage
   import imm_gen_stage_pkg::*;
#(
   parameter int SKID = 1
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [31:0]       i_inst,
   input  logic [31:0]       i_pc,
   input  logic [FMT_W-1:0]  i_format,
   input  logic              i_flush,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [31:0]       o_imm,
   output logic [31:0]       o_target,
   output logic [31:0]       o_pc,
   output logic [FMT_W-1:0]  o_format,
   output logic              o_illegal
);

   state_t state;
   state_t next_state;
   entry_t in_entry;
   entry_t out_q;
   entry_t skid_q;
   logic   load_out;
   logic   load_skid;
   logic   move_skid;
   logic   accept;
   logic   deliver;
   logic   in_illegal;
   logic   [31:0] in_imm;

   // Immediate and target are resolved on the input side so the stored
   // entry is complete one cycle after acceptance.
   imm_decode u_imm_decode (
      .inst    (i_inst),
      .fmt     (i_format),
      .imm     (in_imm),
      .illegal (in_illegal)
   );

   always_comb begin
      in_entry.pc      = i_pc;
      in_entry.imm     = in_imm;
      in_entry.target  = i_pc + in_imm;
      in_entry.fmt     = i_format;
      in_entry.illegal = in_illegal;
   end

   // Ready is a pure decode of the state register
   generate
      if (SKID != 0) begin : g_skid
         assign o_ready = (state != ST_TWO);
      end else begin : g_single
         assign o_ready = (state == ST_EMPTY);
      end
   endgenerate

   assign o_valid = (state != ST_EMPTY);
   assign accept  = i_valid && o_ready;
   assign deliver = o_valid && i_ready;

   always_comb begin
      next_state = state;
      load_out   = 1'b0;
      load_skid  = 1'b0;
      move_skid  = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (accept) begin
               next_state = ST_ONE;
               load_out   = 1'b1;
            end
         end
         ST_ONE: begin
            if (accept && deliver) begin
               load_out = 1'b1;
            end else if (accept && (SKID != 0)) begin
               next_state = ST_TWO;
               load_skid  = 1'b1;
            end else if (deliver) begin
               next_state = ST_EMPTY;
            end
         end
         ST_TWO: begin
            // The skid entry is older than anything upstream, so it
            // refills the output register before new input is taken.
            if (deliver) begin
               next_state = ST_ONE;
               move_skid  = 1'b1;
            end
         end
         default: begin
            next_state = ST_EMPTY;
         end
      endcase
      if (i_flush) begin
         next_state = ST_EMPTY;
         load_out   = 1'b0;
         load_skid  = 1'b0;
         move_skid  = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= ST_EMPTY;
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         state <= next_state;
         if (load_out) begin
            out_q <= in_entry;
         end else if (move_skid) begin
            out_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_entry;
         end
      end
   end

   assign o_imm     = out_q.imm;
   assign o_target  = out_q.target;
   assign o_pc      = out_q.pc;
   assign o_format  = out_q.fmt;
   assign o_illegal = out_q.illegal;

endmodule
`default_nettype wire

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 Parameter: SKID, default 1, meaning 1 = two-entry output buffer (full-throughput), 0 = single entry (o_ready registered-low while holding).
REQ-002 i_clk  input  1  sole clock, all state updates on rising edge.
REQ-003 i_rst  input  1  synchronous, active-high reset.
REQ-004 i_valid  input  1  upstream instruction valid.
REQ-005 o_ready  output  1  stage can accept this cycle; registered, depends only on internal state.
REQ-006 i_inst  input  32  instruction word.
REQ-007 i_pc  input  32  instruction address.
REQ-008 i_format  input  6  one-hot format from decoder: [0]R [1]I [2]S [3]B [4]U [5]J.
REQ-009 i_flush  input  1  discard all held and incoming entries.
REQ-010 o_valid  output  1  output entry valid.
REQ-011 i_ready  input  1  downstream accepts output entry.
REQ-012 o_imm  output  32  sign/zero-formatted immediate.
REQ-013 o_target  output  32  o_pc + o_imm, modulo 2^32.
REQ-014 o_pc  output  32  pc of output entry.
REQ-015 o_format  output  6  i_format of output entry, unchanged.
REQ-016 o_illegal  output  1  i_format was not exactly one-hot.

Function
REQ-017 Transfer in when i_valid && o_ready; transfer out when o_valid && i_ready.
REQ-018 Immediates: I = sext(inst[31:20]); S = sext({inst[31:25],inst[11:7]}); B = sext({inst[31],inst[7],inst[30:25],inst[11:8],0}); U = {inst[31:12],12'b0}; J = sext({inst[31],inst[19:12],inst[20],inst[30:21],0}); R = 0.
REQ-019 Non-one-hot i_format (including zero): o_imm = 0, o_illegal = 1, entry still passes through.
REQ-020 Immediate and target computed before registering; latency accept-to-o_valid exactly 1 cycle when empty.
REQ-021 FSM states EMPTY, ONE (output reg valid), TWO (output + skid valid; SKID=1 only).
REQ-022 EMPTY: accept -> ONE. ONE: accept && !out -> TWO (SKID=1); out && !accept -> EMPTY; accept && out -> ONE with new entry; else hold.
REQ-023 TWO: out -> ONE, skid entry moves to output reg; no accept (o_ready = 0).
REQ-024 o_ready = (state != TWO) for SKID=1; o_ready = (state == EMPTY) for SKID=0.
REQ-025 Output fields held stable while o_valid && !i_ready.
REQ-026 Ordering strictly FIFO; no entry dropped or duplicated except on flush/reset.
REQ-027 i_flush: next state EMPTY, incoming transfer that cycle discarded, o_valid = 0 next cycle; flush overrides accept and out.
REQ-028 o_target wraps on overflow, no flag.

Reset
REQ-029 i_rst overrides i_flush and all transfers; next cycle state EMPTY.
REQ-030 After reset: o_valid = 0, o_ready = 1, o_imm = o_target = o_pc = 0, o_format = 0, o_illegal = 0.
REQ-031 Reset mid-operation discards all held entries.

Structure
REQ-032 Shared package holds format bit-index constants (FMT_R..FMT_J) and FSM state encoding.
REQ-033 One combinational sub-module imm_decode (inst, format -> imm, illegal); instantiated once at input, result stored per buffer entry.

Verification
REQ-034 i_inst 0xFFF00093, fmt I, pc 0x0 -> o_imm 0xFFFFFFFF, o_target 0xFFFFFFFF, one cycle later.
REQ-035 i_inst 0xFE000EE3, fmt B, pc 0x100 -> o_imm 0xFFFFFFFC, o_target 0x000000FC.
REQ-036 i_inst 0x123450B7 fmt U, then 0x0080006F fmt J pc 0x200, i_ready low 3 cycles -> o_ready low after 2nd accept, outputs 0x12345000 then 0x00000008/target 0x208 in order.
REQ-037 Back-to-back 10 valid entries with i_ready toggling every cycle -> all 10 emerge in order, none lost.
REQ-038 State TWO, assert i_flush with i_valid -> next cycle o_valid 0, o_ready 1; i_rst with i_flush -> reset values of REQ-030.
REQ-039 i_format 0b000000 and 0b000110 -> o_imm 0, o_illegal 1.
